// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_LINES     = 16;
  localparam int DEF_MEM_WORDS = 1024;
  localparam int DEF_MISS_LAT  = 4;
  localparam int STAT_W        = 16;

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Backing word store: synchronous write port, combinational read port.
module dmem_array #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // NOTE: storage arrays carry no reset; clearing them would need a per-word
  // reset network and the contents are meaningful only once written.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Direct-mapped, write-through, no-write-allocate cache in front of a
// fixed-latency word store; stalls the ME stage on misses and writes.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LINES     = DEF_LINES,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int MISS_LAT  = DEF_MISS_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic [STAT_W-1:0] hits,
  output logic [STAT_W-1:0] misses
);

  localparam int IDX_W = $clog2(LINES);
  localparam int MW_W  = $clog2(MEM_WORDS);
  localparam int TAG_W = MW_W - IDX_W;
  localparam int LAT_W = $clog2(MISS_LAT) + 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MISS_LAT - 1);

  // Tag covers only the store's word-index bits, so wrapped aliases of one
  // store word share a line and a write can never leave a stale alias cached.
  logic [MW_W-1:0]  word;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag_in;

  assign word   = addr[MW_W+1:2];
  assign index  = word[IDX_W-1:0];
  assign tag_in = word[MW_W-1:IDX_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:MW_W+2], addr[1:0]};

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic        is_write, is_read, hit;
  logic        fill, commit, stall_raw;
  logic        hit_evt, miss_evt;
  logic [31:0] store_rdata;

  assign is_write = wmem;
  assign is_read  = rmem & ~wmem;
  assign hit      = valid[index] && (tag_q[index] == tag_in);

  dmem_array #(
    .WORDS (MEM_WORDS)
  ) u_array (
    .clock (clock),
    .we    (commit),
    .waddr (word),
    .wdata (wdata),
    .raddr (word),
    .rdata (store_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    rdata     = '0;
    fill      = 1'b0;
    commit    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (is_write || (is_read && !hit)) begin
          stall_raw = 1'b1;
          state_nxt = ST_BUSY;
          cnt_nxt   = LAT_INIT;
        end else if (is_read) begin
          rdata = data_q[index];
        end
      end
      ST_BUSY: begin
        stall_raw = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = ST_DONE;
          commit    = is_write;
          fill      = is_read;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (is_read) rdata = data_q[index];
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset is asynchronous, so an in-flight operation drops stall at once.
  assign stall = reset & stall_raw;

  assign hit_evt  = (state == ST_IDLE) && is_read && hit;
  assign miss_evt = (state == ST_IDLE) && is_read && !hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      valid  <= '0;
      hits   <= '0;
      misses <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fill)     valid[index] <= 1'b1;
      if (hit_evt)  hits   <= sat_inc(hits);
      if (miss_evt) misses <= sat_inc(misses);
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[index]  <= tag_in;
      data_q[index] <= store_rdata;
    end else if (commit && hit) begin
      data_q[index] <= wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: miss/hit timing, write-through,
// no-write-allocate, aliasing, reset abort and read+write priority.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic        rmem  = 1'b0;
  logic        wmem  = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic [15:0] hits, misses;

  int checks = 0;
  int errors = 0;

  localparam int STALL_FULL = DEF_MISS_LAT + 1;

  dmem_responder dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .rmem   (rmem),
    .wmem   (wmem),
    .wdata  (wdata),
    .rdata  (rdata),
    .stall  (stall),
    .hits   (hits),
    .misses (misses)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request just after a rising edge; hold it until stall is low
  // at a falling edge, capture rdata there, then release after the next edge.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int stalls,
                        output logic [31:0] rd);
    rmem   = r;
    wmem   = w;
    addr   = a;
    wdata  = d;
    stalls = 0;
    @(negedge clock);
    while (stall && stalls < 50) begin
      stalls++;
      @(negedge clock);
    end
    rd = rdata;
    @(posedge clock);
    #1;
    rmem = 1'b0;
    wmem = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  int          n;
  logic [31:0] rd;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_hits", {16'b0, hits}, 32'd0);
    check("reset_misses", {16'b0, misses}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Populate the store through the write port (no allocation on write miss).
    do_req(1'b0, 1'b1, 32'h40, 32'h12345678, n, rd);
    check("pre_w40_stall", n, STALL_FULL);
    do_req(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, n, rd);
    do_req(1'b0, 1'b1, 32'h100, 32'h0, n, rd);
    check("pre_w_misses", {16'b0, misses}, 32'd0);

    do_req(1'b1, 1'b0, 32'h40, '0, n, rd);
    check("rd40_miss_stall", n, STALL_FULL);
    check("rd40_miss_data", rd, 32'h12345678);
    do_req(1'b1, 1'b0, 32'h40, '0, n, rd);
    check("rd40_hit_stall", n, 32'd0);
    check("rd40_hit_data", rd, 32'h12345678);
    check("seq1_hits", {16'b0, hits}, 32'd1);
    check("seq1_misses", {16'b0, misses}, 32'd1);

    do_req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, n, rd);
    check("wr40_stall", n, STALL_FULL);
    check("wr40_done_rdata", rd, 32'h0);
    do_req(1'b1, 1'b0, 32'h40, '0, n, rd);
    check("rd40_after_wr_stall", n, 32'd0);
    check("rd40_after_wr_data", rd, 32'hDEADBEEF);

    // 0x1040 wraps onto the same store word as 0x40.
    do_req(1'b1, 1'b0, 32'h1040, '0, n, rd);
    check("wrap_stall", n, 32'd0);
    check("wrap_data", rd, 32'hDEADBEEF);
    check("seq2_hits", {16'b0, hits}, 32'd3);

    pulse_reset();
    check("rst2_hits", {16'b0, hits}, 32'd0);
    do_req(1'b1, 1'b0, 32'h40, '0, n, rd);
    check("conf_a_stall", n, STALL_FULL);
    check("conf_a_data", rd, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h80, '0, n, rd);
    check("conf_b_stall", n, STALL_FULL);
    check("conf_b_data", rd, 32'hCAFEF00D);
    do_req(1'b1, 1'b0, 32'h40, '0, n, rd);
    check("conf_c_stall", n, STALL_FULL);
    check("conf_c_data", rd, 32'hDEADBEEF);
    check("conf_misses", {16'b0, misses}, 32'd3);
    check("conf_hits", {16'b0, hits}, 32'd0);

    do_req(1'b0, 1'b1, 32'h200, 32'h11111111, n, rd);
    check("wr200_stall", n, STALL_FULL);
    do_req(1'b1, 1'b0, 32'h200, '0, n, rd);
    check("rd200_noalloc_stall", n, STALL_FULL);
    check("rd200_data", rd, 32'h11111111);
    check("rd200_misses", {16'b0, misses}, 32'd4);

    // Abort a write in its second BUSY cycle.
    rmem  = 1'b0;
    wmem  = 1'b1;
    addr  = 32'h100;
    wdata = 32'hAAAA5555;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("abort_pre_stall", {31'b0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
    wmem = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_req(1'b1, 1'b0, 32'h100, '0, n, rd);
    check("abort_rd_stall", n, STALL_FULL);
    check("abort_rd_data", rd, 32'h0);
    check("abort_misses", {16'b0, misses}, 32'd1);

    do_req(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, n, rd);
    check("rw_stall", n, STALL_FULL);
    check("rw_misses", {16'b0, misses}, 32'd1);
    do_req(1'b1, 1'b0, 32'h8, '0, n, rd);
    check("rw_rd_data", rd, 32'h5A5A5A5A);
    check("rw_rd_misses", {16'b0, misses}, 32'd2);
    do_req(1'b1, 1'b0, 32'h8, '0, n, rd);
    check("rw_hit_stall", n, 32'd0);
    check("rw_hit_data", rd, 32'h5A5A5A5A);

    // Idle with a cached address on the bus but no request.
    addr = 32'h8;
    repeat (3) begin
      @(negedge clock);
      check("idle_stall", {31'b0, stall}, 32'd0);
      check("idle_rdata", rdata, 32'h0);
    end
    check("idle_hits", {16'b0, hits}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
